// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned N x N -> 2N shift-and-add multiplier, one adder reused over N cycles.
// Ports: clk, rst (sync, active-high), start/a/b request (captured in IDLE), busy (RUN), done (1-cycle pulse),
// product (2N, held until next done), ovf (upper half non-zero when MUL_OVF_EN is defined, else tied 0).
module shift_add_multiplier #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           ovf
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] mcand, acc, q;
  logic [CW-1:0] cnt;
  logic [N:0] sum;
  logic [2*N-1:0] shifted;
  logic last;
  // carry-out lands in the top bit of the shifted chain, so nothing is dropped
  assign sum = {1'b0, acc} + {1'b0, q[0] ? mcand : {N{1'b0}}};
  assign shifted = {sum, q[N-1:1]};
  assign last = cnt == CW'(N - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mcand <= a;
        q     <= b;
        acc   <= '0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        {acc, q} <= shifted;
        if (last) product <= shifted;
        else cnt <= cnt + 1'b1;
      end
    end
  end
`ifdef MUL_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= |shifted[2*N-1:N];
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed scoreboard bench for shift_add_multiplier at N=8 and N=32.
module tb_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic busy, done, ovf;
  logic [15:0] product;
  logic start32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic busy32, done32, ovf32;
  logic [63:0] product32;
  int checks = 0;
  int failures = 0;
  logic [15:0] sb[$];
  logic [15:0] prev = '0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .ovf(ovf)
  );
  shift_add_multiplier #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product(product32), .ovf(ovf32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ovf(input logic [63:0] p, input int n);
`ifdef MUL_OVF_EN
    return (p >> n) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic pop_chk(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_product"}, product, e);
    chk({tag, "_ovf"}, ovf, exp_ovf(e, 8));
    prev = e;
  endtask

  task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y);
    int n;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    sb.push_back(16'(x) * 16'(y));
    @(negedge clk);
    start = 1'b0;
    a = 8'hA5; b = 8'h5A;
    n = 1;
    while (!done && n < 20) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_hold"}, product, prev);
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    pop_chk(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, t_last;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;

    run_op("t1_3x5", 8'd3, 8'd5);
    run_op("t2_255x255", 8'd255, 8'd255);
    run_op("t3_0x200", 8'd0, 8'd200);
    run_op("t3_200x1", 8'd200, 8'd1);

    @(negedge clk);
    a = 8'd7; b = 8'd9; start = 1'b1;
    t_last = 0;
    for (int p = 0; p < 3; p++) begin
      sb.push_back(16'd63);
      n = 0;
      while (!done && n < 15) begin
        if (p == 0 && n == 2) begin a = 8'd1; b = 8'd1; end
        if (p == 0 && n == 6) begin a = 8'd7; b = 8'd9; end
        @(negedge clk);
        n++;
      end
      chk("t4_done", done, 1);
      if (p > 0) chk("t4_period", n + 1, 10);
      if (p == 2) start = 1'b0;
      pop_chk("t4_hold_start");
      @(negedge clk);
    end
    chk("t4_no_requeue", busy, 0);

    a = 8'd11; b = 8'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_iter4", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_product", product, 0);
    chk("t5_rst_ovf", ovf, 0);
    prev = '0;
    run_op("t5_12x12", 8'd12, 8'd12);

    rst = 1'b1; start = 1'b1; a = 8'd2; b = 8'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);

    a32 = 32'hFFFF_FFFF; b32 = 32'd2; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_latency", n, 33);
    chk("t6_product", product32, 64'h1_FFFF_FFFE);
    chk("t6_ovf", ovf32, exp_ovf(64'h1_FFFF_FFFE, 32));
    chk("t6_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
